// File: rtl/gf256_inverter_if.sv
// Operand/result handshake bundle for the GF(2^8) inverter.
// master drives operands and accepts results; slave is the inverter.
interface gf256_inverter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/gf256_inverter.sv
// Sequential AES-field inverter: a^254 by MSB-first square-and-multiply,
// one shared combinational GF(2^8) multiplier, one operand in flight.
module gf256_inverter #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input logic           clk,
  input logic           rst,
  gf256_inverter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] acc;
  logic [7:0] acc_nx;
  logic [7:0] x_reg;
  logic [7:0] x_nx;
  logic [7:0] res;
  logic [7:0] res_nx;
  logic [2:0] idx;
  logic [2:0] idx_nx;
  logic [7:0] op_b;
  logic [7:0] prod;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] h;
    logic [7:0] p;
    h = a;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ h;
      h = xtime(h);
    end
    return p;
  endfunction

  // Exponent 8'hFE: every bit but bit 0 is set, so each SQR except
  // the last is followed by a MUL with the captured operand.
  assign op_b = (state == MUL) ? x_reg : acc;
  assign prod = gf_mul(acc, op_b);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    x_nx     = x_reg;
    res_nx   = res;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          x_nx     = bus.in_data;
          acc_nx   = 8'h01;
          idx_nx   = 3'd7;
          state_nx = SQR;
        end
      end
      SQR: begin
        acc_nx = prod;
        if (idx == 3'd0) begin
          res_nx   = prod;
          state_nx = DONE;
        end else begin
          state_nx = MUL;
        end
      end
      MUL: begin
        acc_nx   = prod;
        idx_nx   = idx - 3'd1;
        state_nx = SQR;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 8'h01;
      x_reg <= 8'h00;
      res   <= 8'h00;
      idx   <= 3'd7;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      x_reg <= x_nx;
      res   <= res_nx;
      idx   <= idx_nx;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = res;

endmodule

// File: tb/tb_gf256_inverter.sv
// Randomized scoreboard bench for gf256_inverter against a
// polynomial-arithmetic reference inverse.
module tb_gf256_inverter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf256_inverter_if bus ();

  gf256_inverter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total    = 0;
  int rdy_mode = 0;

  logic [7:0] exp_q[$];
  logic [7:0] op_q[$];
  int         acc_q[$];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    logic [7:0] b;
    if (a == 8'h00) return 8'h00;
    for (int i = 1; i < 256; i++) begin
      b = 8'(i);
      if (ref_mul(a, b) == 8'h01) return b;
    end
    return 8'h00;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every result hand-off.
  initial begin
    bit prev_v = 1'b0;
    bit handed = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        handed = 1'b0;
      end else begin
        if (handed) begin
          chk("in_ready_after_handoff", int'(bus.in_ready), 1);
          chk("out_valid_cleared", int'(bus.out_valid), 0);
          handed = 1'b0;
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            if (!prev_v) fail_now("spurious_out_valid");
          end else begin
            if (!prev_v) begin
              chk($sformatf("latency_a%02h", op_q[0]), cyc - acc_q[0], 15);
              chk("in_ready_in_done", int'(bus.in_ready), 0);
            end
            if (bus.out_ready) begin
              chk($sformatf("result_a%02h", op_q[0]), int'(bus.out_data), int'(exp_q[0]));
              void'(exp_q.pop_front());
              void'(op_q.pop_front());
              void'(acc_q.pop_front());
              handed = 1'b1;
            end else begin
              chk($sformatf("held_a%02h", op_q[0]), int'(bus.out_data), int'(exp_q[0]));
            end
          end
        end
        prev_v = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [7:0] a, input bit hold, output int edge_no);
    int n;
    n = 0;
    edge_no = -1;
    @(posedge clk);
    #2;
    bus.in_data  = a;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (!bus.in_ready) begin
      fail_now("accept_timeout");
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_inv(a));
      op_q.push_back(a);
      acc_q.push_back(cyc + 1);
      edge_no = cyc + 1;
      @(posedge clk);
      #2;
      if (!hold) bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      op_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e;
    int eds[4];
    logic [7:0] b2b[4];
    int n;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);

    // Single operand, pulse valid.
    rdy_mode = 0;
    send(8'h53, 1'b0, e);
    drain(60);

    // Back-to-back with valid held high.
    b2b[0] = 8'h01;
    b2b[1] = 8'h02;
    b2b[2] = 8'hCA;
    b2b[3] = 8'h00;
    for (int i = 0; i < 4; i++) send(b2b[i], i != 3, eds[i]);
    drain(60);
    for (int i = 0; i < 3; i++) chk($sformatf("spacing_%0d", i), eds[i+1] - eds[i], 17);

    // Backpressure: result held, new operand during DONE ignored.
    rdy_mode = 1;
    send(8'h53, 1'b0, e);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now("bp_no_valid");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    bus.in_data  = 8'h02;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_out_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    drain(20);
    send(8'hFF, 1'b0, e);
    drain(60);

    // Operand changes right after acceptance.
    send(8'h02, 1'b0, e);
    bus.in_data = 8'hFF;
    drain(60);

    // Reset mid-computation.
    send(8'h53, 1'b0, e);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    op_q.delete();
    acc_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_data", int'(bus.out_data), 0);
    send(8'h02, 1'b0, e);
    drain(60);

    // Exhaustive, random hold/gaps/backpressure, then random extras.
    rdy_mode = 2;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), $urandom_range(0, 1) == 1, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 30; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0, e);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    #2;
    bus.in_valid = 1'b0;
    drain(200);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
